// File: rtl/exposure_timer_pkg.sv
// exposure_pkg: shared constants for the exposure-time counter.
//   S_IDLE / S_RUN    : FSM state encoding (1 bit)
//   *_DEF             : default parameter values for exposure_timer
package exposure_pkg;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int WIDTH_DEF       = 5;
  localparam int EXP_MIN_DEF     = 2;
  localparam int EXP_MAX_DEF     = 30;
  localparam int EXP_DEFAULT_DEF = 2;
endpackage

// File: rtl/exposure_timer_if.sv
// exposure_timer_if: Start/Ovf5 handshake, adjust buttons and readout
// between the exposure-control FSM (master) and exposure_timer (slave).
//   Start        : master -> slave, rising edge launches an exposure
//   Exp_increase : master -> slave, rising edge raises the setting
//   Exp_decrease : master -> slave, rising edge lowers the setting
//   Ovf5         : slave -> master, one-cycle pulse when exposure elapsed
//   Busy         : slave -> master, high while a count runs
//   Exp_time     : slave -> master, current exposure setting
//   dbg_state    : slave -> master, FSM state for observation
// Handshake: Start is edge-triggered, not level; a rise is accepted only
// while the timer is idle. Each accepted rise returns exactly one Ovf5
// pulse N cycles later unless Init/Reset aborts the count. There is no
// back-pressure: Busy is informational, rises seen while busy are dropped.
interface exposure_timer_if #(
  parameter int WIDTH = 5
);
  import exposure_pkg::*;

  logic             Start;
  logic             Exp_increase;
  logic             Exp_decrease;
  logic             Ovf5;
  logic             Busy;
  logic [WIDTH-1:0] Exp_time;
  logic [0:0]       dbg_state;

  modport master (
    output Start, Exp_increase, Exp_decrease,
    input  Ovf5, Busy, Exp_time, dbg_state
  );

  modport slave (
    input  Start, Exp_increase, Exp_decrease,
    output Ovf5, Busy, Exp_time, dbg_state
  );
endinterface

// File: rtl/exposure_timer_rise_detect.sv
// rise_detect: one-register rising-edge detector for a Clk-synchronous input.
//   Clk     : clock
//   Reset   : synchronous active-high reset, clears history
//   Clear   : synchronous clear of history (Init)
//   d_i     : input level
//   rise_o  : d_i & ~previous d_i (combinational from d_i)
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  always_ff @(posedge Clk) begin
    if (Reset || Clear) d_q <= 1'b0;
    else                d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/exposure_timer.sv
// exposure_timer: counts the programmed exposure after a Start rise and
// answers with a single-cycle Ovf5; holds the button-adjusted setting.
//   Clk   : system clock, rising edge
//   Reset : synchronous active-high reset (priority over Init)
//   Init  : synchronous restart: default setting, abort running count
//   bus   : exposure_timer_if slave (Start, buttons, Ovf5, Busy, Exp_time)
module exposure_timer
  import exposure_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int EXP_MIN     = EXP_MIN_DEF,
  parameter int EXP_MAX     = EXP_MAX_DEF,
  parameter int EXP_DEFAULT = EXP_DEFAULT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Init,
  exposure_timer_if.slave   bus
);
  if (EXP_MIN < 1 || EXP_MAX >= (1 << WIDTH) || EXP_MIN > EXP_MAX ||
      EXP_DEFAULT < EXP_MIN || EXP_DEFAULT > EXP_MAX) begin : g_param_check
    $error("exposure_timer: illegal EXP_MIN/EXP_MAX/EXP_DEFAULT for WIDTH");
  end

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(EXP_MIN);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(EXP_MAX);
  localparam logic [WIDTH-1:0] DEF_W = WIDTH'(EXP_DEFAULT);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic start_rise, inc_rise, dec_rise;

  rise_detect u_rd_start (.Clk(Clk), .Reset(Reset), .Clear(Init),
                          .d_i(bus.Start),        .rise_o(start_rise));
  rise_detect u_rd_inc   (.Clk(Clk), .Reset(Reset), .Clear(Init),
                          .d_i(bus.Exp_increase), .rise_o(inc_rise));
  rise_detect u_rd_dec   (.Clk(Clk), .Reset(Reset), .Clear(Init),
                          .d_i(bus.Exp_decrease), .rise_o(dec_rise));

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] exp_q,   exp_d;
  logic             ovf_q,   ovf_d;
  logic             busy_q,  busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    ovf_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          // Cnt starts at N-1 and Ovf5 is raised on the edge where it is 0,
          // which puts the pulse exactly N edges after the Start edge.
          state_d = S_RUN;
          cnt_d   = exp_q - ONE_W;
          busy_d  = 1'b1;
        end else if (inc_rise && !dec_rise) begin
          if (exp_q < MAX_W) exp_d = exp_q + ONE_W;
        end else if (dec_rise && !inc_rise) begin
          if (exp_q > MIN_W) exp_d = exp_q - ONE_W;
        end
      end
      S_RUN: begin
        // Start and button rises are intentionally ignored here.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE_W;
        end else begin
          ovf_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || Init) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      exp_q   <= DEF_W;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Ovf5      = ovf_q;
  assign bus.Busy      = busy_q;
  assign bus.Exp_time  = exp_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_exposure_timer.sv
// Directed bench for exposure_timer: a per-cycle vector table for the basic
// exposure and adjust behaviour, then hand-written multi-cycle sequences.
module tb_exposure_timer;
  logic clk = 1'b0;
  logic rst;
  logic init;
  int   errors = 0;
  int   checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  exposure_timer_if #(.WIDTH(5)) bus ();

  exposure_timer dut (
    .Clk   (clk),
    .Reset (rst),
    .Init  (init),
    .bus   (bus)
  );

  typedef struct {
    logic       start;
    logic       inc;
    logic       dec;
    logic       ovf;
    logic       busy;
    logic [4:0] etime;
  } vec_t;

  vec_t vecs[20];

  // driver: apply inputs after a falling edge, let one rising edge pass,
  // return at the next falling edge where outputs are sampled
  task automatic drive(input logic s, input logic i, input logic d, input logic n);
    bus.Start        = s;
    bus.Exp_increase = i;
    bus.Exp_decrease = d;
    init             = n;
    @(negedge clk);
  endtask

  task automatic pulse_inc();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_dec();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard comparisons
  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_time(input string name, input logic [4:0] exp);
    checks++;
    if (bus.Exp_time !== exp) begin
      errors++;
      $display("FAIL %s: got Exp_time=%0d expected %0d (t=%0t)", name, bus.Exp_time, exp, $time);
    end
  endtask

  task automatic set_vec(input int idx, input logic s, input logic i, input logic d,
                         input logic o, input logic b, input logic [4:0] t);
    vecs[idx].start = s; vecs[idx].inc = i; vecs[idx].dec = d;
    vecs[idx].ovf = o; vecs[idx].busy = b; vecs[idx].etime = t;
  endtask

  initial begin
    int ovf_cnt;

    rst = 1'b1; init = 1'b0;
    bus.Start = 1'b0; bus.Exp_increase = 1'b0; bus.Exp_decrease = 1'b0;
    repeat (3) @(negedge clk);
    chk_bit("reset_ovf", bus.Ovf5, 1'b0);
    chk_bit("reset_busy", bus.Busy, 1'b0);
    chk_time("reset_time", 5'd2);
    chk_bit("reset_state", bus.dbg_state[0], 1'b0);
    rst = 1'b0;

    //              st inc dec ovf busy time
    set_vec( 0, 1, 0, 0, 0, 1, 5'd2);  // Start edge t0
    set_vec( 1, 1, 0, 0, 0, 1, 5'd2);  // held, still counting
    set_vec( 2, 0, 0, 0, 1, 0, 5'd2);  // t0+2: Ovf5
    set_vec( 3, 0, 0, 0, 0, 0, 5'd2);  // single-cycle pulse
    set_vec( 4, 0, 1, 0, 0, 0, 5'd3);  // inc
    set_vec( 5, 0, 1, 0, 0, 0, 5'd3);  // held inc: no repeat
    set_vec( 6, 0, 0, 0, 0, 0, 5'd3);
    set_vec( 7, 0, 0, 1, 0, 0, 5'd2);  // dec
    set_vec( 8, 0, 0, 0, 0, 0, 5'd2);
    set_vec( 9, 0, 0, 1, 0, 0, 5'd2);  // dec at min holds
    set_vec(10, 0, 0, 0, 0, 0, 5'd2);
    set_vec(11, 1, 1, 0, 0, 1, 5'd2);  // start+inc: inc discarded
    set_vec(12, 0, 1, 0, 0, 1, 5'd2);
    set_vec(13, 0, 0, 0, 1, 0, 5'd2);  // old setting N=2 used
    set_vec(14, 0, 0, 0, 0, 0, 5'd2);
    set_vec(15, 1, 0, 0, 0, 1, 5'd2);
    set_vec(16, 0, 1, 0, 0, 1, 5'd2);  // inc rises during RUN
    set_vec(17, 0, 1, 0, 1, 0, 5'd2);
    set_vec(18, 0, 1, 0, 0, 0, 5'd2);  // held across end: no fire
    set_vec(19, 0, 0, 0, 0, 0, 5'd2);

    for (int v = 0; v < 20; v++) begin
      drive(vecs[v].start, vecs[v].inc, vecs[v].dec, 1'b0);
      chk_bit($sformatf("vec%0d_ovf", v), bus.Ovf5, vecs[v].ovf);
      chk_bit($sformatf("vec%0d_busy", v), bus.Busy, vecs[v].busy);
      chk_time($sformatf("vec%0d_time", v), vecs[v].etime);
    end

    // saturate at the top and run a 30-cycle exposure
    for (int k = 0; k < 28; k++) pulse_inc();
    chk_time("inc_to_max", 5'd30);
    pulse_inc();
    chk_time("inc_at_max", 5'd30);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk_bit("max_busy_t0", bus.Busy, 1'b1);
    ovf_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.Ovf5 === 1'b1) ovf_cnt++;
      chk_bit($sformatf("max_ovf_k%0d", k), bus.Ovf5, (k == 30));
      if (k == 29) chk_bit("max_busy_k29", bus.Busy, 1'b1);
      if (k == 30) chk_bit("max_busy_k30", bus.Busy, 1'b0);
    end
    chk_bit("max_single_pulse", (ovf_cnt == 1), 1'b1);

    // decrements and simultaneous buttons
    for (int k = 0; k < 3; k++) pulse_dec();
    chk_time("dec_to_27", 5'd27);
    for (int k = 0; k < 17; k++) pulse_dec();
    chk_time("dec_to_10", 5'd10);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_time("inc_dec_same", 5'd10);

    // setting 10: inc at t0+3 and Start rise at t0+5 have no effect;
    // Start then stays high after Ovf5 and must not retrigger
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      drive((k >= 5), (k == 3), 1'b0, 1'b0);
      chk_bit($sformatf("s10_ovf_k%0d", k), bus.Ovf5, (k == 10));
      if (k >= 11) chk_bit($sformatf("s10_busy_k%0d", k), bus.Busy, 1'b0);
    end
    chk_time("s10_time_after", 5'd10);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_bit("restart_low_busy", bus.Busy, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk_bit("restart_high_busy", bus.Busy, 1'b1);
    repeat (12) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_bit("restart_done_busy", bus.Busy, 1'b0);

    // setting 20, Init during the cycle after edge t0+7
    for (int k = 0; k < 10; k++) pulse_inc();
    chk_time("inc_to_20", 5'd20);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    ovf_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      drive(1'b0, 1'b0, 1'b0, (k == 8));
      if (bus.Ovf5 === 1'b1) ovf_cnt++;
      if (k == 7) chk_bit("init_busy_k7", bus.Busy, 1'b1);
      if (k == 8) begin
        chk_bit("init_busy_k8", bus.Busy, 1'b0);
        chk_time("init_time_k8", 5'd2);
      end
    end
    chk_bit("init_no_ovf", (ovf_cnt == 0), 1'b1);

    // Reset in the middle of a 5-cycle exposure
    for (int k = 0; k < 3; k++) pulse_inc();
    chk_time("inc_to_5", 5'd5);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_bit("pre_rst_busy", bus.Busy, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_bit("rst_run_ovf", bus.Ovf5, 1'b0);
    chk_bit("rst_run_busy", bus.Busy, 1'b0);
    chk_time("rst_run_time", 5'd2);
    chk_bit("rst_run_state", bus.dbg_state[0], 1'b0);
    rst = 1'b0;
    ovf_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.Ovf5 === 1'b1) ovf_cnt++;
    end
    chk_bit("rst_no_ovf", (ovf_cnt == 0), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/exposure_timer.md
Name: exposure_timer

Overview:
Exposure-time counter that answers the exposure-control FSM's Start/Ovf5 handshake. The FSM pulses Start to begin an exposure. This block counts the programmed exposure length and returns a single-cycle Ovf5. It also holds the user-adjustable exposure setting: increment/decrement buttons, saturating between limits, locked while an exposure runs. It sits beside FSM_ex_control in the camera top level, sharing Clk, Reset and Init.

Parameters:
WIDTH, 5, width of exposure register and down-counter
EXP_MIN, 2, lowest exposure setting (clock cycles)
EXP_MAX, 30, highest exposure setting (clock cycles)
EXP_DEFAULT, 2, setting loaded on Reset and Init

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Init  input  1  sync restart: restore EXP_DEFAULT, abort any running count
Start  input  1  from FSM; rising edge launches an exposure count
Exp_increase  input  1  button; rising edge = setting +1
Exp_decrease  input  1  button; rising edge = setting -1
Ovf5  output  1  one-cycle pulse: exposure time elapsed
Busy  output  1  high while a count is in progress
Exp_time  output  WIDTH  current exposure setting (for display/readout)

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Reset). Reset has priority over Init. Init has priority over all other inputs.
- Reset/Init values: Exp_time=EXP_DEFAULT; Ovf5=0; Busy=0; state IDLE; Cnt=0; edge-detect history regs=0.
- Edge detect: each of Start, Exp_increase, Exp_decrease is registered once. rise = in & ~in_q. Inputs are synchronous to Clk; no extra synchroniser.
- States:
  - IDLE: rise(Start) -> RUN, Cnt<=Exp_time-1, Busy<=1.
  - RUN: Cnt!=0 -> Cnt<=Cnt-1. Cnt==0 -> Ovf5<=1, Busy<=0, state IDLE.
- Latency: rise(Start) detected at edge t0 -> Ovf5 high from edge t0+N to edge t0+N+1 (N = Exp_time latched at t0). Ovf5 is exactly one cycle wide.
- Exp_time is sampled only at t0. Changes during RUN cannot affect the running count.
- Adjust (IDLE only): rise(inc) and Exp_time<EXP_MAX -> +1. rise(dec) and Exp_time>EXP_MIN -> -1. At limits: hold, no wrap.
- Simultaneous rise(inc) and rise(dec): no change.
- Button edges during RUN are discarded (not queued). Edge history still updates, so a button held across the end of RUN does not fire.
- Start rising during RUN: ignored. No retrigger or extension.
- Start edge in the same cycle Ovf5 is set: ignored, since the state is RUN at that edge. A new Start edge is accepted from t0+N+1 on.
- rise(Start) and a button edge in the same IDLE cycle: exposure launches with the old Exp_time. The button edge is discarded.
- Init or Reset during RUN: count aborted, Ovf5 never pulses, Busy=0 next cycle.
- Arithmetic is unsigned WIDTH-bit. EXP_MAX must be < 2^WIDTH and EXP_MIN >= 1. Elaboration check fails otherwise.

Decomposition:
- Package exposure_pkg: state encoding constants (S_IDLE=0, S_RUN=1) and default EXP_MIN/EXP_MAX/EXP_DEFAULT values.
- Sub-module rise_detect (1-bit register + AND). Instantiated three times, with Clk/Reset passed through.
- Main FSM, counter and setting register stay in exposure_timer.

Test Plan:
- Reset, then Start rise at t0 with default setting -> Exp_time=2, Busy=1 at t0, Ovf5 high only at t0+2, Busy=0 at t0+2.
- 28 Exp_increase pulses -> Exp_time=30. Further pulse -> still 30. Start -> Ovf5 exactly 30 cycles after t0, one cycle wide.
- From 30, three Exp_decrease pulses -> 27. From 2, Exp_decrease -> stays 2. Inc+dec same cycle at 10 -> stays 10.
- Setting 10, Start at t0, Exp_increase at t0+3 and second Start rise at t0+5 -> Ovf5 at t0+10 only, Exp_time still 10 afterward.
- Setting 20, Start, Init at t0+7 -> Busy=0 at t0+8, no Ovf5 through t0+40, Exp_time=2.
- Start held high continuously after Ovf5 -> no second exposure until Start goes low then high again. Reset asserted mid-RUN -> all outputs at reset values next edge.
